// File: rtl/display_driver_scan_sequencer_pkg.sv
// Shared definitions for the display driver scan sequencer.
//   scan_state_e : scan FSM states
//   width_of     : address/plane field width for a count (minimum 1 bit)
//   cnt_width    : width of the BCM display counter, sized for the longest plane
//   bcm_weight   : OE-on cycles for a bit plane (base_time << plane)
package display_driver_scan_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FLUSH,
        ST_WAIT,
        ST_LATCH
    } scan_state_e;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int base_time, input int bitwidth);
        return $clog2(base_time << (bitwidth - 1)) + 1;
    endfunction

    function automatic int bcm_weight(input int base_time, input int plane);
        return base_time << plane;
    endfunction

endpackage

// File: rtl/display_driver_scan_sequencer_if.sv
// Pixel-pipe and panel-side signals driven by the scan sequencer.
//   fb_addr     : framebuffer read address (row*columns + col)
//   go          : advance/accept pixel in the RGB pipe
//   select      : bit plane presented to the RGB pipe
//   shift       : panel shift strobe, aligned with RGB pipe output
//   lat         : panel latch pulse
//   oe_n        : panel output enable, active-low
//   row_addr    : panel row address
//   frame_start : pulse on the first go of row 0 plane 0
// master = sequencer side, slave = pipe/panel side.
interface display_driver_scan_sequencer_if #(
    parameter int COLUMNS  = 64,
    parameter int ROWS     = 16,
    parameter int BITWIDTH = 8
);
    import display_driver_scan_sequencer_pkg::*;

    localparam int COL_W  = width_of(COLUMNS);
    localparam int ROW_W  = width_of(ROWS);
    localparam int SEL_W  = width_of(BITWIDTH);
    localparam int ADDR_W = COL_W + ROW_W;

    logic [ADDR_W-1:0] fb_addr;
    logic              go;
    logic [SEL_W-1:0]  select;
    logic              shift;
    logic              lat;
    logic              oe_n;
    logic [ROW_W-1:0]  row_addr;
    logic              frame_start;

    modport master (
        output fb_addr, go, select, shift, lat, oe_n, row_addr, frame_start
    );

    modport slave (
        input fb_addr, go, select, shift, lat, oe_n, row_addr, frame_start
    );

endinterface

// File: rtl/display_driver_bcm_timer.sv
// Loadable down-counter that times the BCM display window of one bit plane.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : number of OE-on cycles for the plane being latched
//   done_o     : counter is zero (no display window running)
//   oe_n_o     : panel output enable, low while the counter is nonzero
module display_driver_bcm_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o,
    output logic             oe_n_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
    assign oe_n_o = (cnt_q == '0);

endmodule

// File: rtl/display_driver_scan_sequencer.sv
// Scan sequencer: walks rows, BCM bit planes and columns, issues framebuffer
// addresses and go/select into the RGB pipe, and generates shift/lat/oe_n for
// the panel.
//   clk, rst : clock, synchronous active-high reset
//   enable   : run scanning (sampled in IDLE and at each latch)
//   busy     : FSM not idle or a display window still running
//   bus      : pipe/panel signals (master side)
module display_driver_scan_sequencer
    import display_driver_scan_sequencer_pkg::*;
#(
    parameter int COLUMNS     = 64,
    parameter int ROWS        = 16,
    parameter int BITWIDTH    = 8,
    parameter int PIPE_LENGTH = 2,
    parameter int BASE_TIME   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic busy,
    display_driver_scan_sequencer_if.master bus
);

    localparam int COL_W  = width_of(COLUMNS);
    localparam int ROW_W  = width_of(ROWS);
    localparam int SEL_W  = width_of(BITWIDTH);
    localparam int ADDR_W = COL_W + ROW_W;
    localparam int CNT_W  = cnt_width(BASE_TIME, BITWIDTH);
    localparam int FL_W   = width_of(PIPE_LENGTH);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [SEL_W-1:0] PLANE_LAST = SEL_W'(BITWIDTH - 1);
    localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(PIPE_LENGTH - 1);

    scan_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SEL_W-1:0]  plane_q, plane_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [SEL_W-1:0]  sel_hold_q;
    logic [ROW_W-1:0]  row_addr_q;
    logic [PIPE_LENGTH-1:0] go_dly_q;

    logic             go;
    logic             lat;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             timer_done;
    logic             oe_n;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        plane_d  = plane_q;
        flush_d  = flush_q;
        go       = 1'b0;
        lat      = 1'b0;
        load     = 1'b0;
        load_val = CNT_W'(bcm_weight(BASE_TIME, int'(plane_q)));
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SHIFT;
                    col_d   = '0;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            ST_SHIFT: begin
                go = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    flush_d = '0;
                    state_d = ST_FLUSH;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_d = flush_q + 1'b1;
                // An idle display counter lets the latch follow the flush
                // directly instead of spending a cycle in WAIT.
                if (flush_q == FL_LAST) begin
                    state_d = timer_done ? ST_LATCH : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                lat  = 1'b1;
                load = 1'b1;
                if (plane_q == PLANE_LAST) begin
                    plane_d = '0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    plane_d = plane_q + 1'b1;
                end
                state_d = enable ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            plane_q     <= '0;
            flush_q     <= '0;
            addr_hold_q <= '0;
            sel_hold_q  <= '0;
            row_addr_q  <= '0;
            go_dly_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            flush_q <= flush_d;
            if (go) begin
                addr_hold_q <= {row_q, col_q};
                sel_hold_q  <= plane_q;
            end
            if (lat) begin
                row_addr_q <= row_q;
            end
            // go delayed by the pipe latency becomes the panel shift strobe
            go_dly_q[0] <= go;
            for (int i = 1; i < PIPE_LENGTH; i++) begin
                go_dly_q[i] <= go_dly_q[i-1];
            end
        end
    end

    display_driver_bcm_timer #(
        .CNT_W (CNT_W)
    ) u_bcm_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .done_o     (timer_done),
        .oe_n_o     (oe_n)
    );

    // Address/select follow the scan while go is high and hold otherwise.
    assign bus.fb_addr     = go ? {row_q, col_q} : addr_hold_q;
    assign bus.select      = go ? plane_q : sel_hold_q;
    assign bus.go          = go;
    assign bus.shift       = go_dly_q[PIPE_LENGTH-1];
    assign bus.lat         = lat;
    assign bus.oe_n        = oe_n;
    assign bus.row_addr    = row_addr_q;
    assign bus.frame_start = go && (col_q == '0) && (row_q == '0) && (plane_q == '0);
    assign busy            = (state_q != ST_IDLE) || !timer_done;

endmodule

// File: tb/tb_display_driver_scan_sequencer.sv
// Directed bench for display_driver_scan_sequencer with columns=4, rows=2,
// bitwidth=2, pipe_length=2, base_time=8. Cycle i is the window just after
// the i-th rising edge following the cycle in which enable was raised.
module tb_display_driver_scan_sequencer;

    localparam int COLUMNS     = 4;
    localparam int ROWS        = 2;
    localparam int BITWIDTH    = 2;
    localparam int PIPE_LENGTH = 2;
    localparam int BASE_TIME   = 8;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy;

    display_driver_scan_sequencer_if #(
        .COLUMNS  (COLUMNS),
        .ROWS     (ROWS),
        .BITWIDTH (BITWIDTH)
    ) bus ();

    display_driver_scan_sequencer #(
        .COLUMNS     (COLUMNS),
        .ROWS        (ROWS),
        .BITWIDTH    (BITWIDTH),
        .PIPE_LENGTH (PIPE_LENGTH),
        .BASE_TIME   (BASE_TIME)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-derived timeline for one enabled run (enable dropped in cycle 65).
    int go_lo   [6] = '{1, 8, 18, 36, 46, 64};
    int go_base [6] = '{0, 0, 4, 4, 0, 0};
    int go_sel  [6] = '{0, 1, 0, 1, 0, 1};
    int lat_at  [6] = '{7, 17, 35, 45, 63, 73};
    int oe_lo   [6] = '{8, 18, 36, 46, 64, 74};
    int oe_hi   [6] = '{15, 33, 43, 61, 71, 89};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int i);
        int  w;
        int  s;
        int  last;
        bit  l;
        bit  oe_on;
        w = -1; s = -1; last = -1; l = 0; oe_on = 0;
        for (int k = 0; k < 6; k++) begin
            if (i >= go_lo[k] && i <= go_lo[k] + COLUMNS - 1) w = k;
            if (i >= go_lo[k] + PIPE_LENGTH && i <= go_lo[k] + PIPE_LENGTH + COLUMNS - 1) s = k;
            if (go_lo[k] + COLUMNS - 1 < i) last = k;
            if (lat_at[k] == i) l = 1;
            if (i >= oe_lo[k] && i <= oe_hi[k]) oe_on = 1;
        end
        check_val($sformatf("go@%0d", i), 32'(bus.go), 32'(w >= 0));
        if (w >= 0) begin
            check_val($sformatf("fb_addr@%0d", i), 32'(bus.fb_addr), 32'(go_base[w] + i - go_lo[w]));
            check_val($sformatf("select@%0d", i), 32'(bus.select), 32'(go_sel[w]));
        end else if (last >= 0) begin
            check_val($sformatf("fb_addr_hold@%0d", i), 32'(bus.fb_addr), 32'(go_base[last] + COLUMNS - 1));
            check_val($sformatf("select_hold@%0d", i), 32'(bus.select), 32'(go_sel[last]));
        end
        check_val($sformatf("shift@%0d", i), 32'(bus.shift), 32'(s >= 0));
        check_val($sformatf("lat@%0d", i), 32'(bus.lat), 32'(l));
        check_val($sformatf("oe_n@%0d", i), 32'(bus.oe_n), 32'(!oe_on));
        check_val($sformatf("frame_start@%0d", i), 32'(bus.frame_start), 32'(i == 1 || i == 46));
        check_val($sformatf("row_addr@%0d", i), 32'(bus.row_addr), 32'(i >= 36 && i <= 63));
        check_val($sformatf("busy@%0d", i), 32'(busy), 32'(i <= 89));
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;

        // Reset and idle
        step();
        check_val("rst_go", 32'(bus.go), 0);
        check_val("rst_select", 32'(bus.select), 0);
        check_val("rst_fb_addr", 32'(bus.fb_addr), 0);
        check_val("rst_shift", 32'(bus.shift), 0);
        check_val("rst_lat", 32'(bus.lat), 0);
        check_val("rst_oe_n", 32'(bus.oe_n), 1);
        check_val("rst_row_addr", 32'(bus.row_addr), 0);
        check_val("rst_frame_start", 32'(bus.frame_start), 0);
        check_val("rst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check_val("idle_go", 32'(bus.go), 0);
            check_val("idle_shift", 32'(bus.shift), 0);
            check_val("idle_lat", 32'(bus.lat), 0);
            check_val("idle_oe_n", 32'(bus.oe_n), 1);
            check_val("idle_row_addr", 32'(bus.row_addr), 0);
            check_val("idle_busy", 32'(busy), 0);
        end

        // Full scan: planes, BCM windows, row wrap, then enable drop in SHIFT col=1
        enable = 1'b1;
        for (int i = 1; i <= 95; i++) begin
            step();
            check_cycle(i);
            if (i == 65) enable = 1'b0;
        end

        // Restart, then reset in the middle of a display window
        enable = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            check_cycle(i);
        end
        rst = 1'b1;
        step();
        check_val("mid_rst_oe_n", 32'(bus.oe_n), 1);
        check_val("mid_rst_shift", 32'(bus.shift), 0);
        check_val("mid_rst_lat", 32'(bus.lat), 0);
        check_val("mid_rst_row_addr", 32'(bus.row_addr), 0);
        check_val("mid_rst_go", 32'(bus.go), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        check_val("restart_go", 32'(bus.go), 1);
        check_val("restart_fb_addr", 32'(bus.fb_addr), 0);
        check_val("restart_select", 32'(bus.select), 0);
        check_val("restart_frame_start", 32'(bus.frame_start), 1);
        step();
        check_val("restart_fb_addr1", 32'(bus.fb_addr), 1);
        check_val("restart_frame_start1", 32'(bus.frame_start), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
